// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: ALU ops, opcodes,
// funct codes, FSM states and datapath mux selects.
package mcpu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;
    localparam logic [2:0] ALU_LUI = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MADR, S_MRD, S_MWB, S_MWR,
        S_REXE, S_RWB, S_IEXE, S_IWB, S_BR, S_JMP
    } state_t;

    typedef enum logic [1:0] { CLS_NONE, CLS_R, CLS_I } dec_cls_t;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    function automatic logic funct_ok(input logic [5:0] fn);
        case (fn)
            FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Control unit <-> datapath bundle: IR fields and zero flag in, enables and
// mux selects out. master = control unit, slave = datapath.
interface mcpu_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we;
    logic       i_or_d;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state_o;
    logic       illegal;

    modport master (
        input  opcode, funct, zero,
        output pc_we, i_or_d, mem_we, ir_we, reg_we, reg_dst, wd_sel,
               alu_src_a, alu_src_b, ext_op, alu_op, pc_src, state_o, illegal
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_we, i_or_d, mem_we, ir_we, reg_we, reg_dst, wd_sel,
               alu_src_a, alu_src_b, ext_op, alu_op, pc_src, state_o, illegal
    );
endinterface

// File: rtl/mcpu_alu_dec.sv
// Combinational ALU-op / immediate-extension decode for the R-type and
// I-type execute and write-back states.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  dec_cls_t   i_cls,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_ext_op
);
    always_comb begin
        o_alu_op = ALU_ADD;
        o_ext_op = 1'b0;
        case (i_cls)
            CLS_R: begin
                case (i_funct)
                    FN_SUB, FN_SUBU: o_alu_op = ALU_SUB;
                    FN_AND:          o_alu_op = ALU_AND;
                    FN_OR:           o_alu_op = ALU_OR;
                    FN_NOR:          o_alu_op = ALU_NOR;
                    FN_SLT, FN_SLTU: o_alu_op = ALU_SLT;
                    FN_SRA:          o_alu_op = ALU_SRA;
                    default:         o_alu_op = ALU_ADD;
                endcase
            end
            CLS_I: begin
                case (i_opcode)
                    OP_SLTI: begin o_alu_op = ALU_SLT; o_ext_op = 1'b1; end
                    OP_ANDI: o_alu_op = ALU_AND;
                    OP_ORI:  o_alu_op = ALU_OR;
                    OP_LUI:  o_alu_op = ALU_LUI;
                    default: o_ext_op = 1'b1;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS control FSM: Moore outputs from state and the IR fields
// latched in DECODE; the branch PC write is the only output that sees zero.
module mcpu_ctrl
    import mcpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mcpu_ctrl_if.master  bus
);
    state_t     r_state, w_next;
    logic [5:0] r_opcode, r_funct;
    dec_cls_t   w_cls;
    logic [2:0] w_dec_op;
    logic       w_dec_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Later states decode from these copies so the IR may change after DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= '0;
            r_funct  <= '0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= bus.opcode;
            r_funct  <= bus.funct;
        end
    end

    assign w_cls = (r_state == S_REXE || r_state == S_RWB) ? CLS_R :
                   (r_state == S_IEXE || r_state == S_IWB) ? CLS_I : CLS_NONE;

    mcpu_alu_dec u_alu_dec (
        .i_cls    (w_cls),
        .i_opcode (r_opcode),
        .i_funct  (r_funct),
        .o_alu_op (w_dec_op),
        .o_ext_op (w_dec_ext)
    );

    assign bus.state_o = r_state;

    always_comb begin
        w_next        = S_FETCH;
        bus.pc_we     = 1'b0;
        bus.i_or_d    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.ir_we     = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_dst   = RD_RT;
        bus.wd_sel    = WD_ALUOUT;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = SRCB_B;
        bus.ext_op    = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.pc_src    = PCS_ALU;
        bus.illegal   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                bus.ir_we     = 1'b1;
                bus.pc_we     = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                w_next        = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMMSH;
                bus.ext_op    = 1'b1;
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MADR;
                    OP_RTYPE: begin
                        w_next      = funct_ok(bus.funct) ? S_REXE : S_FETCH;
                        bus.illegal = ~funct_ok(bus.funct);
                    end
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_ANDI, OP_ORI, OP_LUI: w_next = S_IEXE;
                    OP_BEQ, OP_BNE:          w_next = S_BR;
                    OP_J, OP_JAL:            w_next = S_JMP;
                    default: begin
                        w_next      = S_FETCH;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            S_MADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_op    = 1'b1;
                w_next        = (r_opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                bus.i_or_d = 1'b1;
                w_next     = S_MWB;
            end
            S_MWB: begin
                bus.reg_we = 1'b1;
                bus.wd_sel = WD_MDR;
            end
            S_MWR: begin
                bus.i_or_d = 1'b1;
                bus.mem_we = 1'b1;
            end
            S_REXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = w_dec_op;
                w_next        = S_RWB;
            end
            S_RWB: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = RD_RD;
                bus.alu_op  = w_dec_op;
            end
            S_IEXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = w_dec_op;
                bus.ext_op    = w_dec_ext;
                w_next        = S_IWB;
            end
            S_IWB: begin
                bus.reg_we = 1'b1;
                bus.alu_op = w_dec_op;
                bus.ext_op = w_dec_ext;
            end
            S_BR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_src    = PCS_ALUOUT;
                bus.pc_we     = (r_opcode == OP_BEQ) ? bus.zero : ~bus.zero;
            end
            S_JMP: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = PCS_JUMP;
                // jal: PC already holds PC+4, so $31 gets the return address.
                if (r_opcode == OP_JAL) begin
                    bus.reg_we  = 1'b1;
                    bus.reg_dst = RD_RA;
                    bus.wd_sel  = WD_PC;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: per-instruction expected output trace built from the
// instruction-level rules, applied to a table of vectors and random programs.
module tb_mcpu_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we, i_or_d, mem_we, ir_we, reg_we;
        logic [1:0] reg_dst, wd_sel;
        logic       a;
        logic [1:0] b;
        logic       ext;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       ill;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cpi;
        logic       has_exe;
        logic [2:0] exe_aop;
        logic       exe_ext;
        logic       exe_pcwe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    obs_t exq[$];
    vec_t tq[$];

    mcpu_ctrl_if bus ();
    mcpu_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state_o;     o.pc_we = bus.pc_we;   o.i_or_d = bus.i_or_d;
        o.mem_we = bus.mem_we;  o.ir_we = bus.ir_we;   o.reg_we = bus.reg_we;
        o.reg_dst = bus.reg_dst; o.wd_sel = bus.wd_sel; o.a = bus.alu_src_a;
        o.b = bus.alu_src_b;    o.ext = bus.ext_op;    o.aop = bus.alu_op;
        o.pcs = bus.pc_src;     o.ill = bus.illegal;
        return o;
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    // Expected output trace for one instruction, FETCH through its last state.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        obs_t o;
        int   r_aop;
        exq.delete();
        o = blank(4'd1); o.ir_we = 1'b1; o.pc_we = 1'b1; o.b = 2'd1;
        exq.push_back(o);
        o = blank(4'd2); o.b = 2'd3; o.ext = 1'b1;
        case (fn)
            6'h20, 6'h21: r_aop = 0;
            6'h22, 6'h23: r_aop = 1;
            6'h24:        r_aop = 3;
            6'h25:        r_aop = 2;
            6'h27:        r_aop = 4;
            6'h2A, 6'h2B: r_aop = 5;
            6'h03:        r_aop = 6;
            default:      r_aop = -1;
        endcase
        case (op)
            6'h23, 6'h2B: begin
                exq.push_back(o);
                o = blank(4'd3); o.a = 1'b1; o.b = 2'd2; o.ext = 1'b1;
                exq.push_back(o);
                if (op == 6'h23) begin
                    o = blank(4'd4); o.i_or_d = 1'b1; exq.push_back(o);
                    o = blank(4'd5); o.reg_we = 1'b1; o.wd_sel = 2'd1; exq.push_back(o);
                end else begin
                    o = blank(4'd6); o.i_or_d = 1'b1; o.mem_we = 1'b1; exq.push_back(o);
                end
            end
            6'h00: begin
                if (r_aop < 0) begin
                    o.ill = 1'b1; exq.push_back(o);
                end else begin
                    exq.push_back(o);
                    o = blank(4'd7); o.a = 1'b1; o.aop = 3'(r_aop); exq.push_back(o);
                    o = blank(4'd8); o.reg_we = 1'b1; o.reg_dst = 2'd1; o.aop = 3'(r_aop);
                    exq.push_back(o);
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
                exq.push_back(o);
                o = blank(4'd9); o.a = 1'b1; o.b = 2'd2;
                case (op)
                    6'h0A:   begin o.aop = 3'd5; o.ext = 1'b1; end
                    6'h0C:   o.aop = 3'd3;
                    6'h0D:   o.aop = 3'd2;
                    6'h0F:   o.aop = 3'd7;
                    default: o.ext = 1'b1;
                endcase
                exq.push_back(o);
                o.st = 4'd10; o.a = 1'b0; o.b = 2'd0; o.reg_we = 1'b1;
                exq.push_back(o);
            end
            6'h04, 6'h05: begin
                exq.push_back(o);
                o = blank(4'd11); o.a = 1'b1; o.aop = 3'd1; o.pcs = 2'd1;
                o.pc_we = (op == 6'h04) ? z : ~z;
                exq.push_back(o);
            end
            6'h02, 6'h03: begin
                exq.push_back(o);
                o = blank(4'd12); o.pc_we = 1'b1; o.pcs = 2'd2;
                if (op == 6'h03) begin o.reg_we = 1'b1; o.reg_dst = 2'd2; o.wd_sel = 2'd2; end
                exq.push_back(o);
            end
            default: begin
                o.ill = 1'b1; exq.push_back(o);
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Entered on a negedge with the DUT in FETCH; returns in the next FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             output int cyc, output obs_t exe_obs);
        build(op, fn, z);
        cyc = 0;
        exe_obs = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                bus.opcode = op; bus.funct = fn;
            end else if (k >= 2) begin
                bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
            end
            bus.zero = (k < exq.size() && exq[k].st == 4'd11) ? z : 1'($urandom);
            #1;
            if (k > 0 && bus.state_o == 4'd1) break;
            if (k < exq.size())
                chk($sformatf("op%02h fn%02h z%0d cyc%0d", op, fn, z, k),
                    32'(sample()), 32'(exq[k]));
            else
                chk($sformatf("op%02h overrun state", op), 32'(bus.state_o), 32'd1);
            if (k == 2) exe_obs = sample();
            cyc = k + 1;
            @(negedge clk);
        end
        chk($sformatf("op%02h fn%02h cycles", op, fn), 32'(cyc), 32'(exq.size()));
    endtask

    function automatic void add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int cpi, input logic he, input logic [2:0] aop,
                                input logic ext, input logic pcwe);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.cpi = cpi; v.has_exe = he;
        v.exe_aop = aop; v.exe_ext = ext; v.exe_pcwe = pcwe;
        tq.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        obs_t eo;
        logic [5:0] ops [13] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
                                 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};
        logic [5:0] fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                                 6'h2A, 6'h2B, 6'h03};
        logic [5:0] op, fn;
        obs_t fetch_exp;

        add(6'h23, 6'h00, 1'b0, 5, 1'b1, 3'd0, 1'b1, 1'b0);
        add(6'h2B, 6'h00, 1'b1, 4, 1'b1, 3'd0, 1'b1, 1'b0);
        add(6'h00, 6'h20, 1'b0, 4, 1'b1, 3'd0, 1'b0, 1'b0);
        add(6'h00, 6'h22, 1'b0, 4, 1'b1, 3'd1, 1'b0, 1'b0);
        add(6'h00, 6'h24, 1'b1, 4, 1'b1, 3'd3, 1'b0, 1'b0);
        add(6'h00, 6'h25, 1'b0, 4, 1'b1, 3'd2, 1'b0, 1'b0);
        add(6'h00, 6'h27, 1'b0, 4, 1'b1, 3'd4, 1'b0, 1'b0);
        add(6'h00, 6'h2A, 1'b0, 4, 1'b1, 3'd5, 1'b0, 1'b0);
        add(6'h00, 6'h03, 1'b0, 4, 1'b1, 3'd6, 1'b0, 1'b0);
        add(6'h00, 6'h23, 1'b0, 4, 1'b1, 3'd1, 1'b0, 1'b0);
        add(6'h08, 6'h00, 1'b0, 4, 1'b1, 3'd0, 1'b1, 1'b0);
        add(6'h0D, 6'h00, 1'b0, 4, 1'b1, 3'd2, 1'b0, 1'b0);
        add(6'h0F, 6'h00, 1'b0, 4, 1'b1, 3'd7, 1'b0, 1'b0);
        add(6'h0A, 6'h00, 1'b0, 4, 1'b1, 3'd5, 1'b1, 1'b0);
        add(6'h0C, 6'h00, 1'b0, 4, 1'b1, 3'd3, 1'b0, 1'b0);
        add(6'h04, 6'h00, 1'b1, 3, 1'b1, 3'd1, 1'b0, 1'b1);
        add(6'h04, 6'h00, 1'b0, 3, 1'b1, 3'd1, 1'b0, 1'b0);
        add(6'h05, 6'h00, 1'b1, 3, 1'b1, 3'd1, 1'b0, 1'b0);
        add(6'h05, 6'h00, 1'b0, 3, 1'b1, 3'd1, 1'b0, 1'b1);
        add(6'h02, 6'h00, 1'b0, 3, 1'b1, 3'd0, 1'b0, 1'b1);
        add(6'h03, 6'h00, 1'b0, 3, 1'b1, 3'd0, 1'b0, 1'b1);
        add(6'h3F, 6'h00, 1'b0, 2, 1'b0, 3'd0, 1'b0, 1'b0);
        add(6'h00, 6'h00, 1'b0, 2, 1'b0, 3'd0, 1'b0, 1'b0);
        add(6'h01, 6'h20, 1'b0, 2, 1'b0, 3'd0, 1'b0, 1'b0);

        fetch_exp = blank(4'd1);
        fetch_exp.ir_we = 1'b1; fetch_exp.pc_we = 1'b1; fetch_exp.b = 2'd1;

        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset idle", 32'(sample()), 32'(blank(4'd0)));
        rst = 1'b0;
        @(negedge clk);

        foreach (tq[i]) begin
            run_instr(tq[i].op, tq[i].fn, tq[i].z, cyc, eo);
            chk($sformatf("tbl%0d cpi", i), 32'(cyc), 32'(tq[i].cpi));
            if (tq[i].has_exe)
                chk($sformatf("tbl%0d exe aop/ext/pcwe", i),
                    {27'd0, eo.aop, eo.ext, eo.pc_we},
                    {27'd0, tq[i].exe_aop, tq[i].exe_ext, tq[i].exe_pcwe});
        end

        // Reset mid-REXE must return to IDLE without waiting for a clock edge.
        bus.opcode = 6'h00; bus.funct = 6'h20;
        #1 chk("pre-reset fetch", 32'(bus.state_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre-reset rexe", 32'(bus.state_o), 32'd7);
        rst = 1'b1;
        #1 chk("async reset", 32'(sample()), 32'(blank(4'd0)));
        @(negedge clk);
        #1 chk("reset held", 32'(sample()), 32'(blank(4'd0)));
        rst = 1'b0;
        @(negedge clk);
        #1 chk("fetch after reset", 32'(sample()), 32'(fetch_exp));

        for (int n = 0; n < 300; n++) begin
            op = (($urandom % 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
            fn = (($urandom % 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
            run_instr(op, fn, 1'($urandom), cyc, eo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
